fir_sequencer: RTL

Control unit for the sample-processing FIR datapath. Accepts one sample at a time from the input handshake and issues a fixed per-sample micro-operation sequence to the register-file/ALU datapath: history shift, sample store, accumulator clear, then alternating-sign multiply-accumulate over all taps. It also owns the coefficient-load sequence and the running sample count that flags every SAMPLE_LIMIT processed samples.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/fir_sample_counter.sv | 41 ++++
 rtl/fir_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared opcode/state types and register-map helpers for the FIR control unit.
package fir_pkg;

   typedef enum logic [2:0] {
      OP_NOP         = 3'd0,
      OP_LOAD_SAMPLE = 3'd1,
      OP_LOAD_COEF   = 3'd2,
      OP_COPY        = 3'd3,
      OP_MUL         = 3'd4,
      OP_ADD         = 3'd5,
      OP_SUB         = 3'd6,
      OP_CLEAR       = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE, S_COEF, S_SHIFT, S_STORE, S_ZERO, S_MUL, S_ACC, S_ERR
   } state_e;

   localparam logic [3:0] REG_ACC    = 4'd0;
   localparam logic [3:0] REG_NEWEST = 4'd1;

   typedef struct packed {
      op_e        op;
      logic [3:0] src1;
      logic [3:0] src2;
      logic [3:0] dest;
      logic [2:0] coeff_idx;
      logic       data_taken;
      logic       modwait;
      logic       err;
   } ctrl_t;

   // Coefficient Fk lives just above the N-deep sample history.
   function automatic logic [3:0] coef_reg(input int num_taps, input logic [2:0] k);
      return 4'(num_taps + 1 + int'(k));
   endfunction

   function automatic logic [3:0] scratch_reg(input int num_taps);
      return 4'(2 * num_taps + 1);
   endfunction

endpackage

// File: rtl/fir_sample_counter.sv
// Sample counter with clear, enable and rollover; flags when the count sits
// exactly at the rollover value.
module fir_sample_counter #(
   parameter int CNT_BITS = 10,
   parameter int ROLLOVER = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic count_enable_i,
   output logic flag_o
);

   localparam logic [CNT_BITS-1:0] ROLL = CNT_BITS'(ROLLOVER);

   logic [CNT_BITS-1:0] count_q, count_d;
   logic                flag_q;

   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (count_enable_i)
         count_d = (count_q == ROLL) ? CNT_BITS'(1) : count_q + CNT_BITS'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep all registers updating on the same edge.
      if (rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= (count_d == ROLL);
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/fir_sequencer.sv
// FIR datapath control unit: per-sample shift/store/clear/MAC sequence,
// coefficient load sequence and the processed-sample counter.
module fir_sequencer import fir_pkg::*; #(
   parameter int NUM_TAPS     = 4,
   parameter int SAMPLE_LIMIT = 1000,
   parameter int CNT_BITS     = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_ready,
   input  logic       load_coeff,
   input  logic       overflow,
   output logic [2:0] op,
   output logic [3:0] src1,
   output logic [3:0] src2,
   output logic [3:0] dest,
   output logic [2:0] coeff_idx,
   output logic       data_taken,
   output logic       modwait,
   output logic       err,
   output logic       one_k_samples
);

   localparam logic [2:0] K_LAST    = 3'(NUM_TAPS - 1);
   localparam logic [3:0] R_SCRATCH = scratch_reg(NUM_TAPS);

   state_e     state_q, state_d;
   logic [2:0] k_q, k_d;
   ctrl_t      ctrl_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (load_coeff) begin
               state_d = S_COEF;
               k_d     = '0;
            end else if (data_ready) begin
               state_d = (NUM_TAPS == 1) ? S_STORE : S_SHIFT;
               k_d     = K_LAST;
            end
         end
         S_COEF: begin
            if (k_q == K_LAST) begin
               state_d = S_IDLE;
               k_d     = '0;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         S_SHIFT: begin
            if (k_q == 3'd1) state_d = S_STORE;
            else             k_d     = k_q - 3'd1;
         end
         S_STORE: state_d = S_ZERO;
         S_ZERO: begin
            state_d = S_MUL;
            k_d     = '0;
         end
         S_MUL:   state_d = S_ACC;
         S_ACC: begin
            if (overflow) begin
               state_d = S_ERR;
            end else if (k_q == K_LAST) begin
               state_d = S_IDLE;
               k_d     = '0;
            end else begin
               state_d = S_MUL;
               k_d     = k_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore decode, evaluated on the next state so the outputs come straight from flops.
   function automatic ctrl_t decode(input state_e s, input logic [2:0] k);
      ctrl_t c;
      c = '0;
      case (s)
         S_COEF: begin
            c.op        = OP_LOAD_COEF;
            c.dest      = coef_reg(NUM_TAPS, k);
            c.coeff_idx = k;
            c.modwait   = 1'b1;
         end
         S_SHIFT: begin
            c.op      = OP_COPY;
            c.src1    = 4'(k);
            c.dest    = 4'(k) + 4'd1;
            c.modwait = 1'b1;
         end
         S_STORE: begin
            c.op         = OP_LOAD_SAMPLE;
            c.dest       = REG_NEWEST;
            c.data_taken = 1'b1;
            c.modwait    = 1'b1;
         end
         S_ZERO: begin
            c.op      = OP_CLEAR;
            c.dest    = REG_ACC;
            c.modwait = 1'b1;
         end
         S_MUL: begin
            c.op      = OP_MUL;
            c.src1    = REG_NEWEST + 4'(k);
            c.src2    = coef_reg(NUM_TAPS, k);
            c.dest    = R_SCRATCH;
            c.modwait = 1'b1;
         end
         S_ACC: begin
            c.op      = k[0] ? OP_SUB : OP_ADD;
            c.src1    = REG_ACC;
            c.src2    = R_SCRATCH;
            c.dest    = REG_ACC;
            c.modwait = 1'b1;
         end
         S_ERR:   c.err = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ctrl_q  <= decode(state_d, k_d);
      end
   end

   assign op         = ctrl_q.op;
   assign src1       = ctrl_q.src1;
   assign src2       = ctrl_q.src2;
   assign dest       = ctrl_q.dest;
   assign coeff_idx  = ctrl_q.coeff_idx;
   assign data_taken = ctrl_q.data_taken;
   assign modwait    = ctrl_q.modwait;
   assign err        = ctrl_q.err;

   fir_sample_counter #(
      .CNT_BITS (CNT_BITS),
      .ROLLOVER (SAMPLE_LIMIT)
   ) u_counter (
      .clk            (clk),
      .rst            (rst),
      .clear_i        ((state_q == S_COEF) && (k_q == 3'd0)),
      .count_enable_i (state_q == S_STORE),
      .flag_o         (one_k_samples)
   );

endmodule
